alu_dsp_cluster: RTL and testbench
==================================

ALU_DSP_CLUSTER -- requirements
Module: alu_dsp_cluster

Interface
- REQ-001: The block SHALL provide parameter WIDTH, default 32, as the adder/subtractor operand and result width.
- REQ-002: The block SHALL provide parameter MUL_WIDTH, default 16, as the shift-multiplier operand width; the product width is 2*MUL_WIDTH.
- REQ-003: Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
- REQ-004: Port reset, input, 1, synchronous active-high reset.
- REQ-005: Port in_valid, input, 1, operands on this cycle are sampled.
- REQ-006: Port add_input1, input, WIDTH, adder operand 1.
- REQ-007: Port add_input2, input, WIDTH, adder operand 2.
- REQ-008: Port addsub, input, 1, 0 = add, 1 = subtract.
- REQ-009: Port sub_input1, input, WIDTH, subtractor minuend.
- REQ-010: Port sub_input2, input, WIDTH, subtractor subtrahend.
- REQ-011: Port shift_input, input, MUL_WIDTH, value to be shifted.
- REQ-012: Port shift_mul, input, MUL_WIDTH, multiplier; a one-hot value 2^k shifts left by k.
- REQ-013: Port add_out, output, WIDTH, adder result.
- REQ-014: Port sub_out, output, WIDTH, subtractor result.
- REQ-015: Port shift_out, output, 2*MUL_WIDTH, unsigned product.
- REQ-016: Port out_valid, output, 1, results correspond to operands sampled one cycle earlier.

Function
- REQ-017: Adder SHALL compute add_input1 + add_input2 when addsub=0 and add_input1 - add_input2 when addsub=1.
- REQ-018: Adder arithmetic SHALL be modulo 2^WIDTH, with no carry, borrow or overflow output.
- REQ-019: Subtractor SHALL compute sub_input1 - sub_input2 modulo 2^WIDTH; the result is two's-complement, so 0 - 1 = 0xFFFFFFFF.
- REQ-020: Shifter SHALL compute shift_input * shift_mul as an unsigned full-width product with no truncation.
- REQ-021: For a non-one-hot shift_mul, the shifter SHALL still return the exact product.
- REQ-022: For shift_mul=0, the shifter SHALL return 0.
- REQ-023: Each result SHALL be registered, giving a latency of exactly 1 clk cycle from sampling to output.
- REQ-024: When in_valid=1, all three units SHALL capture their operands on the same edge.
- REQ-025: When in_valid=0, outputs SHALL hold their previous values.
- REQ-026: out_valid SHALL equal in_valid delayed by one cycle.
- REQ-027: Back-to-back in_valid SHALL give a throughput of one result per cycle per unit, with no stalls.
- REQ-028: The three units SHALL be independent; no unit's operands affect another unit's output.
- REQ-029: The block SHALL NOT apply backpressure.

Reset
- REQ-030: While reset=1 at a clk edge, add_out, sub_out, shift_out and out_valid SHALL become 0.
- REQ-031: Reset SHALL take priority over in_valid on the same edge.
- REQ-032: After reset is released, the first valid result SHALL appear one cycle after the first sampled in_valid.
- REQ-033: A reset asserted mid-stream SHALL discard the in-flight result.

Structure
- REQ-034: A shared package SHALL hold the WIDTH and MUL_WIDTH defaults and the addsub encodings ADD=0 and SUB=1.
- REQ-035: The block SHALL contain three leaf sub-modules: adder_dsp, subtractor_dsp and shift_dsp.
- REQ-036: Each leaf SHALL be a single-cycle registered arithmetic unit with its own clk/reset, mappable to one DSP MAC slice.
- REQ-037: The top level SHALL contain only the leaf instances and the out_valid register.

Verification
- REQ-038: Reset then idle -> all outputs 0 and out_valid=0; outputs stay 0 while in_valid=0.
- REQ-039: add 0x7FFFFFFF+1 (addsub=0), then 0x00000005-0x00000007 (addsub=1) -> add_out 0x80000000 then 0xFFFFFFFE, each one cycle after its input.
- REQ-040: sub 0x00000000-0x00000001 -> 0xFFFFFFFF; sub 0x12345678-0x12345678 -> 0x00000000.
- REQ-041: shift_input=0xFFFF with shift_mul=0x8000 -> 0x7FFF8000; shift_input=0x00AB with shift_mul=0x0001 -> 0x000000AB; shift_mul=0x0003 with shift_input=0x0010 -> 0x00000030.
- REQ-042: Three consecutive valid cycles with distinct operands -> three consecutive correct results with out_valid held at 1.
- REQ-043: Reset asserted together with in_valid carrying add operands 1+1 -> add_out stays 0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/alu_dsp_cluster_pkg.sv
// alu_dsp_cluster_pkg: shared widths and add/subtract select encoding
package alu_dsp_cluster_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int MUL_WIDTH_DEF = 16;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} addsub_e;
endpackage

// File: rtl/alu_dsp_cluster_if.sv
// alu_dsp_cluster_if: operand/result bundle for the arithmetic cluster
interface alu_dsp_cluster_if #(parameter int WIDTH = 32, parameter int MUL_WIDTH = 16);
  logic in_valid;
  logic addsub;
  logic [WIDTH-1:0] add_input1;
  logic [WIDTH-1:0] add_input2;
  logic [WIDTH-1:0] sub_input1;
  logic [WIDTH-1:0] sub_input2;
  logic [MUL_WIDTH-1:0] shift_input;
  logic [MUL_WIDTH-1:0] shift_mul;
  logic [WIDTH-1:0] add_out;
  logic [WIDTH-1:0] sub_out;
  logic [2*MUL_WIDTH-1:0] shift_out;
  logic out_valid;
  modport master (
    output in_valid, addsub, add_input1, add_input2, sub_input1, sub_input2, shift_input, shift_mul,
    input add_out, sub_out, shift_out, out_valid
  );
  modport slave (
    input in_valid, addsub, add_input1, add_input2, sub_input1, sub_input2, shift_input, shift_mul,
    output add_out, sub_out, shift_out, out_valid
  );
endinterface

// File: rtl/alu_dsp_cluster_units.sv
// alu_dsp_cluster_units: single-cycle registered add/sub, subtract and multiply leaves
module adder_dsp
  import alu_dsp_cluster_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic addsub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_ff @(posedge clk)
    if (reset) y <= '0;
    else if (en) y <= (addsub == SUB) ? a - b : a + b;
endmodule

module subtractor_dsp
  import alu_dsp_cluster_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_ff @(posedge clk)
    if (reset) y <= '0;
    else if (en) y <= a - b;
endmodule

module shift_dsp
  import alu_dsp_cluster_pkg::*;
#(
  parameter int MUL_WIDTH = MUL_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic [2*MUL_WIDTH-1:0] y
);
  localparam int P = 2 * MUL_WIDTH;
  // a true multiply: one-hot b acts as a left shift, any other b still yields the exact product
  always_ff @(posedge clk)
    if (reset) y <= '0;
    else if (en) y <= P'(a) * P'(b);
endmodule

// File: rtl/alu_dsp_cluster.sv
// alu_dsp_cluster: three independent registered arithmetic units plus a shared valid pipe
module alu_dsp_cluster
  import alu_dsp_cluster_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MUL_WIDTH = MUL_WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  alu_dsp_cluster_if.slave bus
);
  adder_dsp #(.WIDTH(WIDTH)) u_add (
    .clk(clk), .reset(reset), .en(bus.in_valid), .addsub(bus.addsub),
    .a(bus.add_input1), .b(bus.add_input2), .y(bus.add_out)
  );
  subtractor_dsp #(.WIDTH(WIDTH)) u_sub (
    .clk(clk), .reset(reset), .en(bus.in_valid),
    .a(bus.sub_input1), .b(bus.sub_input2), .y(bus.sub_out)
  );
  shift_dsp #(.MUL_WIDTH(MUL_WIDTH)) u_shift (
    .clk(clk), .reset(reset), .en(bus.in_valid),
    .a(bus.shift_input), .b(bus.shift_mul), .y(bus.shift_out)
  );
  always_ff @(posedge clk)
    if (reset) bus.out_valid <= 1'b0;
    else bus.out_valid <= bus.in_valid;
endmodule

// File: tb/tb_alu_dsp_cluster.sv
// tb_alu_dsp_cluster: directed vector table followed by randomized traffic against a reference model
module tb_alu_dsp_cluster;
  typedef struct {
    string name;
    logic rst;
    logic vld;
    logic addsub;
    logic [31:0] a1, a2, s1, s2;
    logic [15:0] si, sm;
    logic [31:0] ea, es, esh;
    logic eov;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  vec_t tbl [12];
  logic [31:0] m_add, m_sub, m_shift;
  logic m_ov;

  alu_dsp_cluster_if #(.WIDTH(32), .MUL_WIDTH(16)) bus ();
  alu_dsp_cluster #(.WIDTH(32), .MUL_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst;
    bus.in_valid = v.vld;
    bus.addsub = v.addsub;
    bus.add_input1 = v.a1;
    bus.add_input2 = v.a2;
    bus.sub_input1 = v.s1;
    bus.sub_input2 = v.s2;
    bus.shift_input = v.si;
    bus.shift_mul = v.sm;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.add_out !== v.ea || bus.sub_out !== v.es || bus.shift_out !== v.esh || bus.out_valid !== v.eov) begin
      n_err++;
      $display("FAIL %s: got add=%h sub=%h shift=%h ov=%b, want add=%h sub=%h shift=%h ov=%b",
               v.name, bus.add_out, bus.sub_out, bus.shift_out, bus.out_valid, v.ea, v.es, v.esh, v.eov);
    end
  endtask

  initial begin
    tbl[0]  = '{"reset",     1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0, 0};
    tbl[1]  = '{"idle",      0, 0, 0, 32'h9, 32'h9, 32'h9, 32'h1, 16'h5, 16'h5, 32'h0, 32'h0, 32'h0, 0};
    tbl[2]  = '{"add_ovf",   0, 1, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h1, 16'hFFFF, 16'h8000,
                32'h80000000, 32'hFFFFFFFF, 32'h7FFF8000, 1};
    tbl[3]  = '{"add_neg",   0, 1, 1, 32'h5, 32'h7, 32'h12345678, 32'h12345678, 16'h00AB, 16'h0001,
                32'hFFFFFFFE, 32'h0, 32'h000000AB, 1};
    tbl[4]  = '{"hold",      0, 0, 0, 32'h1, 32'h1, 32'h4, 32'h2, 16'h3, 16'h3,
                32'hFFFFFFFE, 32'h0, 32'h000000AB, 0};
    tbl[5]  = '{"b2b0",      0, 1, 0, 32'h1, 32'h2, 32'hA, 32'h3, 16'h0010, 16'h0003,
                32'h3, 32'h7, 32'h30, 1};
    tbl[6]  = '{"b2b1",      0, 1, 1, 32'h100, 32'h1, 32'h5, 32'hA, 16'h0, 16'hFFFF,
                32'hFF, 32'hFFFFFFFB, 32'h0, 1};
    tbl[7]  = '{"b2b2",      0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1, 16'hFFFF, 16'hFFFF,
                32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFE0001, 1};
    tbl[8]  = '{"rst_valid", 1, 1, 0, 32'h1, 32'h1, 32'h8, 32'h1, 16'h7, 16'h7, 32'h0, 32'h0, 32'h0, 0};
    tbl[9]  = '{"post_rst",  0, 0, 0, 32'h1, 32'h1, 32'h8, 32'h1, 16'h7, 16'h7, 32'h0, 32'h0, 32'h0, 0};
    tbl[10] = '{"first",     0, 1, 0, 32'h2, 32'h3, 32'h9, 32'h4, 16'h1234, 16'h0100,
                32'h5, 32'h5, 32'h00123400, 1};
    tbl[11] = '{"mid_rst",   1, 1, 1, 32'h50, 32'h20, 32'h30, 32'h10, 16'h2, 16'h2, 32'h0, 32'h0, 32'h0, 0};
    bus.in_valid = 1'b0;
    bus.addsub = 1'b0;
    bus.add_input1 = '0;
    bus.add_input2 = '0;
    bus.sub_input1 = '0;
    bus.sub_input2 = '0;
    bus.shift_input = '0;
    bus.shift_mul = '0;
    for (int i = 0; i < 12; i++) apply(tbl[i]);
    m_add = 32'h0;
    m_sub = 32'h0;
    m_shift = 32'h0;
    m_ov = 1'b0;
    for (int i = 0; i < 300; i++) begin
      vec_t v;
      v.name = "random";
      v.rst = ($urandom_range(0, 15) == 0);
      v.vld = ($urandom_range(0, 3) != 0);
      v.addsub = 1'($urandom);
      v.a1 = $urandom;
      v.a2 = $urandom;
      v.s1 = $urandom;
      v.s2 = $urandom;
      v.si = 16'($urandom);
      v.sm = ($urandom_range(0, 1) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      if (v.rst) begin
        m_add = 32'h0;
        m_sub = 32'h0;
        m_shift = 32'h0;
      end else if (v.vld) begin
        m_add = v.addsub ? v.a1 - v.a2 : v.a1 + v.a2;
        m_sub = v.s1 - v.s2;
        m_shift = 32'(v.si) * 32'(v.sm);
      end
      m_ov = v.vld && !v.rst;
      v.ea = m_add;
      v.es = m_sub;
      v.esh = m_shift;
      v.eov = m_ov;
      apply(v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
